// File: rtl/imem_access_controller.sv
`default_nettype none
// ============================================================================
// Module : imem_access_controller
// Brief  : Arbitrates fetch reads and loader writes onto a byte-wide
//          instruction memory, four big-endian byte beats per word.
// Rev    : 1.0  initial release
// ============================================================================

module imem_access_controller #(
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,

   input  logic                 f_req_valid,
   output logic                 f_req_ready,
   input  logic [63:0]          f_req_addr,
   output logic                 f_rsp_valid,
   input  logic                 f_rsp_ready,
   output logic [31:0]          f_rsp_instr,
   output logic                 f_rsp_err,

   input  logic                 l_req_valid,
   output logic                 l_req_ready,
   input  logic [63:0]          l_req_addr,
   input  logic [31:0]          l_req_data,
   output logic                 l_rsp_valid,
   input  logic                 l_rsp_ready,
   output logic                 l_rsp_err,

   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_we,
   output logic [7:0]           mem_wdata,
   input  logic [7:0]           mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEAT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Highest legal word base: the last four bytes of the memory.
   localparam logic [ADDR_BITS-1:0] MAX_BASE = {{(ADDR_BITS-2){1'b1}}, 2'b00};

   state_t               state;
   state_t               state_nxt;
   logic                 last_loader;
   logic [1:0]           beat;
   logic [ADDR_BITS-1:0] base;
   logic [31:0]          wdata_word;
   logic                 owner_loader;
   logic                 err;
   logic [31:0]          instr;

   logic                 grant_f;
   logic                 grant_l;
   logic                 accept;
   logic                 sel_loader;
   logic [63:0]          sel_addr;
   logic                 in_range;
   logic                 rsp_done;

   // Arbitration, range check and next-state decode.
   always_comb begin
      grant_f    = f_req_valid && (!l_req_valid || last_loader);
      grant_l    = l_req_valid && (!f_req_valid || !last_loader);
      f_req_ready = (state == IDLE) && grant_f;
      l_req_ready = (state == IDLE) && grant_l;
      accept     = f_req_ready || l_req_ready;
      sel_loader = l_req_ready;
      sel_addr   = sel_loader ? l_req_addr : f_req_addr;
      in_range   = (sel_addr[63:ADDR_BITS] == '0) &&
                   (sel_addr[ADDR_BITS-1:0] <= MAX_BASE);
      rsp_done   = owner_loader ? l_rsp_ready : f_rsp_ready;

      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = in_range ? BEAT : RESP;
         BEAT:    if (beat == 2'd3) state_nxt = RESP;
         RESP:    if (rsp_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Memory port and response outputs.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = 8'h00;
      if (state == BEAT) begin
         mem_addr = base + {{(ADDR_BITS-2){1'b0}}, beat};
         mem_we   = owner_loader;
         if (owner_loader) begin
            case (beat)
               2'd0:    mem_wdata = wdata_word[31:24];
               2'd1:    mem_wdata = wdata_word[23:16];
               2'd2:    mem_wdata = wdata_word[15:8];
               default: mem_wdata = wdata_word[7:0];
            endcase
         end
      end

      f_rsp_valid = (state == RESP) && !owner_loader;
      l_rsp_valid = (state == RESP) && owner_loader;
      f_rsp_err   = f_rsp_valid && err;
      l_rsp_err   = l_rsp_valid && err;
      f_rsp_instr = instr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_loader  <= 1'b1;
         beat         <= 2'd0;
         base         <= '0;
         wdata_word   <= 32'h0;
         owner_loader <= 1'b0;
         err          <= 1'b0;
         instr        <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  last_loader  <= sel_loader;
                  owner_loader <= sel_loader;
                  base         <= sel_addr[ADDR_BITS-1:0];
                  wdata_word   <= l_req_data;
                  err          <= !in_range;
                  beat         <= 2'd0;
                  if (!sel_loader) begin
                     instr <= 32'h0;
                  end
               end
            end
            BEAT: begin
               // Counter wraps to 0 after the fourth beat.
               beat <= beat + 2'd1;
               if (!owner_loader) begin
                  case (beat)
                     2'd0:    instr[31:24] <= mem_rdata;
                     2'd1:    instr[23:16] <= mem_rdata;
                     2'd2:    instr[15:8]  <= mem_rdata;
                     default: instr[7:0]   <= mem_rdata;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
